mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed wait states.
// Optional write protection of the low address range is enabled by defining MEM_RESP_WRPROT_EN.
module mem_responder #(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned PROT_LIMIT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready,
    output logic [7:0]  err_cnt
);

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = 4;
    localparam int unsigned ECW = 8;

`ifdef MEM_RESP_WRPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_write;
    logic [DW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_rsp_valid;
    logic [DW-1:0]    r_rsp_rdata;
    logic             r_rsp_err;
    logic [ECW-1:0]   r_err_cnt;
    logic [DW-1:0]    r_mem [DEPTH];

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_cur_write;
    logic [DW-1:0]    w_cur_addr;
    logic [DW-1:0]    w_cur_wdata;
    logic             w_oor;
    logic             w_prot;
    logic             w_err;
    logic             w_mem_we;
    logic [AW-1:0]    w_idx;
    logic [DW-1:0]    w_rdata;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == CW'(WAIT_CYCLES)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM-decoded outputs and strobes
    always_comb begin
        req_ready    = 1'b0;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        if (r_state == S_IDLE) begin
            req_ready = 1'b1;
            w_accept  = req_valid;
        end
        if ((w_state_nxt == S_RESP) && (r_state != S_RESP)) begin
            w_enter_resp = 1'b1;
        end
    end

    // With zero wait states the request resolves in the acceptance cycle, so bypass the capture registers
    always_comb begin
        w_cur_write = r_write;
        w_cur_addr  = r_addr;
        w_cur_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_cur_write = req_write;
            w_cur_addr  = req_addr;
            w_cur_wdata = req_wdata;
        end
        w_oor    = (w_cur_addr >= DW'(DEPTH));
        w_prot   = PROT_EN && w_cur_write && (w_cur_addr < DW'(PROT_LIMIT));
        w_err    = w_oor || w_prot;
        w_mem_we = w_enter_resp && w_cur_write && !w_err && reset;
        w_idx    = w_cur_addr[AW-1:0];
        w_rdata  = r_mem[w_idx];
    end

    // Request capture and wait-state counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Response registers and saturating error counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= (w_err || w_cur_write) ? '0 : w_rdata;
                r_rsp_err   <= w_err;
                if (w_err && (r_err_cnt != {ECW{1'b1}})) begin
                    r_err_cnt <= r_err_cnt + ECW'(1);
                end
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_cur_wdata;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: random and directed requests checked against an array model.
// Honours MEM_RESP_WRPROT_EN when computing expected protection errors.
module tb_mem_responder;

    localparam int unsigned DEPTH       = 32;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam int unsigned PROT_LIMIT  = 16;

`ifdef MEM_RESP_WRPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_ready;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [7:0]  cnt;
        bit          chk_data;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          m_err_cnt = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          rdy_mode  = 0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_rdata;
    logic        prev_err;

    mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .PROT_LIMIT  (PROT_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one call per accepted request, in acceptance order
    function automatic exp_t model_req(input logic wr, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        bit   err;
        int   idx;
        idx        = int'(a);
        err        = (idx >= int'(DEPTH)) || (PROT_EN && wr && (idx < int'(PROT_LIMIT)));
        e.err      = err;
        e.rdata    = 16'h0000;
        e.chk_data = 1'b1;
        if (err) begin
            m_err_cnt = (m_err_cnt >= 255) ? 255 : m_err_cnt + 1;
        end else if (wr) begin
            m_mem[idx]   = d;
            m_known[idx] = 1'b1;
        end else begin
            e.rdata    = m_mem[idx];
            e.chk_data = m_known[idx];
        end
        e.cnt = 8'(m_err_cnt);
        return e;
    endfunction

    // Response consumer: 0 = random, 1 = forced low, 2 = forced high
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1)      rsp_ready = 1'b0;
            else if (rdy_mode == 2) rsp_ready = 1'b1;
            else                    rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: stability while stalled, scoreboard pop at each handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("stall_valid", 32'(rsp_valid), 32'd1);
                    check("stall_data", {15'd0, rsp_err, rsp_rdata}, {15'd0, prev_err, prev_rdata});
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (e.chk_data) check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                        check("err_cnt", 32'(err_cnt), 32'(e.cnt));
                    end
                end
                prev_hold  = rsp_valid && !rsp_ready;
                prev_rdata = rsp_rdata;
                prev_err   = rsp_err;
            end
        end
    end

    // Issue one request, check latency, optionally stall the response for hold cycles
    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d, input int hold);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            check("req_ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        sb_q.push_back(model_req(wr, a, d));
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(WAIT_CYCLES + 1));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 16'($urandom_range(0, 31));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (hold > 0) begin
            rdy_mode = 2;
            @(negedge clk);
            check("pre_hs_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
            check("post_hs_idle", 32'(req_ready), 32'd1);
            check("post_hs_valid", 32'(rsp_valid), 32'd0);
            rdy_mode = 0;
        end
        k = 0;
        while (rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (rsp_valid) check("rsp_drain", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 1'b0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Basic write/read, out-of-range read, stalled response
        issue(1'b1, 16'd20, 16'h1234, 0);
        issue(1'b0, 16'd20, 16'h0000, 0);
        issue(1'b0, 16'd40, 16'h0000, 0);
        rdy_mode = 1;
        issue(1'b0, 16'd20, 16'h0000, 5);
        check("no_extra_accept", 32'(sb_q.size()), 32'd0);

        // Reset during WAIT of a write drops it
        issue(1'b1, 16'd18, 16'h0001, 0);
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'd18;
        req_wdata = 16'hBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check("wait_rst_valid", 32'(rsp_valid), 32'd0);
        check("wait_rst_err", 32'(rsp_err), 32'd0);
        check("wait_rst_rdata", 32'(rsp_rdata), 32'd0);
        check("wait_rst_cnt", 32'(err_cnt), 32'd0);
        m_err_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 16'd18, 16'h0000, 0);

        // Protected-range write then read back
        issue(1'b1, 16'd3, 16'hAAAA, 0);
        issue(1'b0, 16'd3, 16'h0000, 0);

        // Populate the whole array, then random traffic
        for (int i = 0; i < int'(DEPTH); i++) issue(1'b1, 16'(i), 16'($urandom), 0);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) issue(1'($urandom), 16'($urandom), 16'($urandom), 0);
            else issue(1'($urandom), 16'($urandom_range(0, 39)), 16'($urandom), 0);
        end

        // Error counter saturation
        for (int i = 0; i < 257; i++) issue(1'b0, 16'($urandom_range(40, 65535)), 16'h0, 0);
        @(negedge clk);
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
